regfile_param: RTL and testbench
================================

Name: regfile_param

Overview:
Parametrised successor of the 32x32 register file, used in the CPU decode stage. One write port and two read ports, with configurable width and depth and an optional hardwired-zero register. Adds write-to-read bypass and a selectable registered read path. Adds a per-register busy scoreboard so the issue logic can stall on registers with a pending write.

Parameters:
WIDTH, 32, data width of each register and of every data port
ADDR_W, 5, register address width
NUM_REGS, 32, implemented registers (must be ≤ 2^ADDR_W); addresses ≥ NUM_REGS are unimplemented
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never busy
BYPASS, 1, 1 = a read of the register being written this cycle returns data_writeReg
READ_REG, 0, 0 = combinational read (latency 0); 1 = read data and busy outputs registered (latency 1)

Ports:
clock  in  1  single clock; all state updates on the rising edge
ctrl_reset  in  1  synchronous, active-high reset
ctrl_writeEnable  in  1  write strobe
ctrl_writeReg  in  ADDR_W  write address
data_writeReg  in  WIDTH  write data
ctrl_readRegA  in  ADDR_W  read address A
ctrl_readRegB  in  ADDR_W  read address B
ctrl_setBusy  in  1  mark ctrl_busyReg as having a pending write
ctrl_busyReg  in  ADDR_W  register to mark busy
data_readRegA  out  WIDTH  read data A
data_readRegB  out  WIDTH  read data B
busy_readRegA  out  1  busy bit of the register addressed by A
busy_readRegB  out  1  busy bit of the register addressed by B

Behaviour:
- Clocking and reset: one clock, clock. Reset ctrl_reset is synchronous and active-high.
- Reset (ctrl_reset=1 at an edge):
  - every register clears to 0 and every busy bit clears to 0;
  - when READ_REG=1, all four output registers clear to 0;
  - reset overrides a write or setBusy in the same cycle;
  - when READ_REG=0, outputs reflect the cleared state combinationally from the next cycle.
- Write: ctrl_writeEnable=1 at an edge stores data_writeReg into ctrl_writeReg. The write is ignored when the address is ≥ NUM_REGS, or the address is 0 and ZERO_REG=1.
- Busy scoreboard:
  - ctrl_setBusy=1 sets busy[ctrl_busyReg] at the edge;
  - an accepted write clears busy[ctrl_writeReg] at the edge;
  - when both target the same register in the same cycle, set wins and the bit ends at 1;
  - setBusy to reg 0 (ZERO_REG=1) or to an unimplemented address is ignored.
- Read, READ_REG=0: data_readRegX = reg[ctrl_readRegX] combinationally.
- Read, READ_REG=1: the edge captures the same value that READ_REG=0 would output in that cycle, and presents it for the following cycle.
- Read of an unimplemented address, or of reg 0 with ZERO_REG=1: data 0, busy 0.
- Bypass, BYPASS=1: when an accepted write targets the read address in the same cycle:
  - read data = data_writeReg;
  - busy = 0, unless setBusy targets the same register, in which case busy = 1.
- Bypass, BYPASS=0: read data and busy show the pre-edge values; the write becomes visible the cycle after the edge.
- Ports A and B are fully independent. Both may address the same register; both may equal the write address.

Test Plan:
- Reset: assert ctrl_reset 1 cycle after writing 0xDEADBEEF to r5, reading A=5 -> data_readRegA=0 and busy_readRegA=0 from the cycle after reset. With READ_REG=1, the registered outputs also read 0.
- Write/read: write 0x12345678 to r7, then r31=0xFFFFFFFF; read A=7, B=31 -> 0x12345678 and 0xFFFFFFFF. Write 0xAAAA5555 to r0 -> reading r0 returns 0.
- Bypass: same cycle write r3=0xCAFEF00D and read A=3 -> BYPASS=1: A=0xCAFEF00D, busy 0. BYPASS=0: A=old r3 value, then 0xCAFEF00D next cycle.
- Scoreboard: setBusy r9 -> busy_readRegB(B=9)=1. A later write to r9 of 0x00000042 -> busy 0 and data 0x42. Same-cycle setBusy r9 plus write r9 -> busy stays 1 and data updates.
- Latency: READ_REG=1, change A from 4 to 6 (r4=1, r6=2) -> data_readRegA still 1 that cycle, 2 the next.
- Depth: NUM_REGS=16, ADDR_W=5: write r20 = 0x55, read A=20 -> 0 with busy 0; r15 is writable and reads back.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with one write port, two read
// ports, an optional hardwired-zero register, write-to-read bypass, an
// optional registered read stage and a per-register busy scoreboard.
module regfile_param #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int READ_REG = 0
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [WIDTH-1:0]  data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic              ctrl_setBusy,
  input  logic [ADDR_W-1:0] ctrl_busyReg,
  output logic [WIDTH-1:0]  data_readRegA,
  output logic [WIDTH-1:0]  data_readRegB,
  output logic              busy_readRegA,
  output logic              busy_readRegB
);

  // Storage and scoreboard. Every register is reset, so this is flop-based.
  logic [WIDTH-1:0]    regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] busy_reg;

  // One-hot decode of accepted writes and accepted setBusy requests.
  // Addresses at or above NUM_REGS match no bit, so they are dropped here;
  // the zero register never matches when it is hardwired.
  logic [NUM_REGS-1:0] write_hit;
  logic [NUM_REGS-1:0] set_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : gen_decode
      if (ZERO_REG != 0 && gi == 0) begin : gen_zero
        assign write_hit[gi] = 1'b0;
        assign set_hit[gi]   = 1'b0;
      end else begin : gen_impl
        assign write_hit[gi] = ctrl_writeEnable && (ctrl_writeReg == ADDR_W'(gi));
        assign set_hit[gi]   = ctrl_setBusy && (ctrl_busyReg == ADDR_W'(gi));
      end
    end
  endgenerate

  // Register writes and scoreboard update; set beats clear on a collision.
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_reg[i] <= '0;
      end
      busy_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (write_hit[i]) begin
          regs_reg[i] <= data_writeReg;
        end
        if (set_hit[i]) begin
          busy_reg[i] <= 1'b1;
        end else if (write_hit[i]) begin
          busy_reg[i] <= 1'b0;
        end
      end
    end
  end

  // Read address per port: index 0 is port A, index 1 is port B.
  logic [ADDR_W-1:0] read_addr [2];
  assign read_addr[0] = ctrl_readRegA;
  assign read_addr[1] = ctrl_readRegB;

  generate
    for (gi = 0; gi < 2; gi++) begin : gen_port
      logic [WIDTH-1:0] data_next;
      logic             busy_next;

      // Combinational read: unimplemented addresses fall through to 0,
      // then an accepted same-cycle write to this address overrides.
      always_comb begin
        data_next = '0;
        busy_next = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (read_addr[gi] == ADDR_W'(i)) begin
            data_next = regs_reg[i];
            busy_next = busy_reg[i];
          end
        end
        if (BYPASS != 0) begin
          for (int i = 0; i < NUM_REGS; i++) begin
            if (write_hit[i] && (read_addr[gi] == ADDR_W'(i))) begin
              data_next = data_writeReg;
              busy_next = set_hit[i];
            end
          end
        end
      end
    end
  endgenerate

  generate
    if (READ_REG != 0) begin : gen_out_reg
      logic [WIDTH-1:0] data_a_reg;
      logic [WIDTH-1:0] data_b_reg;
      logic             busy_a_reg;
      logic             busy_b_reg;

      // Output stage: present this cycle's read result one cycle later.
      always_ff @(posedge clock) begin
        if (ctrl_reset) begin
          data_a_reg <= '0;
          data_b_reg <= '0;
          busy_a_reg <= 1'b0;
          busy_b_reg <= 1'b0;
        end else begin
          data_a_reg <= gen_port[0].data_next;
          data_b_reg <= gen_port[1].data_next;
          busy_a_reg <= gen_port[0].busy_next;
          busy_b_reg <= gen_port[1].busy_next;
        end
      end

      assign data_readRegA = data_a_reg;
      assign data_readRegB = data_b_reg;
      assign busy_readRegA = busy_a_reg;
      assign busy_readRegB = busy_b_reg;
    end else begin : gen_out_comb
      assign data_readRegA = gen_port[0].data_next;
      assign data_readRegB = gen_port[1].data_next;
      assign busy_readRegA = gen_port[0].busy_next;
      assign busy_readRegB = gen_port[1].busy_next;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: directed test of three regfile_param configurations
// driven from one shared stimulus stream:
//   fast  - defaults (bypass on, combinational read, 32 regs)
//   rreg  - bypass off, registered read
//   small - 16 implemented registers out of a 5-bit space, bypass off
module tb_regfile_param;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        ctrl_setBusy;
  logic [4:0]  ctrl_busyReg;

  logic [31:0] fast_da, fast_db, rreg_da, rreg_db, small_da, small_db;
  logic        fast_ba, fast_bb, rreg_ba, rreg_bb, small_ba, small_bb;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  regfile_param u_fast (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .ctrl_setBusy(ctrl_setBusy), .ctrl_busyReg(ctrl_busyReg),
    .data_readRegA(fast_da), .data_readRegB(fast_db),
    .busy_readRegA(fast_ba), .busy_readRegB(fast_bb)
  );

  regfile_param #(.BYPASS(0), .READ_REG(1)) u_rreg (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .ctrl_setBusy(ctrl_setBusy), .ctrl_busyReg(ctrl_busyReg),
    .data_readRegA(rreg_da), .data_readRegB(rreg_db),
    .busy_readRegA(rreg_ba), .busy_readRegB(rreg_bb)
  );

  regfile_param #(.NUM_REGS(16), .BYPASS(0)) u_small (
    .clock(clock), .ctrl_reset(ctrl_reset), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .ctrl_setBusy(ctrl_setBusy), .ctrl_busyReg(ctrl_busyReg),
    .data_readRegA(small_da), .data_readRegB(small_db),
    .busy_readRegA(small_ba), .busy_readRegB(small_bb)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Start a new cycle just after the rising edge; strobes default low.
  task automatic begin_cycle();
    @(posedge clock);
    #1;
    ctrl_reset       = 1'b0;
    ctrl_writeEnable = 1'b0;
    ctrl_setBusy     = 1'b0;
  endtask

  // Move to mid-cycle, where outputs are sampled.
  task automatic mid();
    @(negedge clock);
  endtask

  initial begin
    ctrl_reset       = 1'b1;
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = '0;
    data_writeReg    = '0;
    ctrl_readRegA    = '0;
    ctrl_readRegB    = '0;
    ctrl_setBusy     = 1'b0;
    ctrl_busyReg     = '0;
    @(posedge clock);
    @(posedge clock);
    #1;
    ctrl_reset = 1'b0;
    mid();
    check_value("init_fast_a", fast_da, 32'h0);
    check_value("init_rreg_a", rreg_da, 32'h0);

    // Reset after a write to r5
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 5; data_writeReg = 32'hDEADBEEF; ctrl_readRegA = 5;
    mid();
    check_value("byp_fast_r5", fast_da, 32'hDEADBEEF);
    check_value("nobyp_small_r5", small_da, 32'h0);
    begin_cycle(); ctrl_reset = 1;
    mid();
    check_value("prerst_fast_r5", fast_da, 32'hDEADBEEF);
    check_value("prerst_small_r5", small_da, 32'hDEADBEEF);
    begin_cycle();
    mid();
    check_value("rst_fast_da", fast_da, 32'h0);
    check_value("rst_fast_ba", 32'(fast_ba), 32'h0);
    check_value("rst_rreg_da", rreg_da, 32'h0);
    check_value("rst_small_da", small_da, 32'h0);

    // Write / read r7 and r31
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 7; data_writeReg = 32'h12345678;
    ctrl_readRegA = 7; ctrl_readRegB = 31;
    mid();
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 31; data_writeReg = 32'hFFFFFFFF;
    mid();
    check_value("wr_fast_r7", fast_da, 32'h12345678);
    check_value("byp_fast_r31", fast_db, 32'hFFFFFFFF);
    check_value("unimpl_small_r31", small_db, 32'h0);
    begin_cycle();
    mid();
    check_value("rreg_r7", rreg_da, 32'h12345678);
    check_value("rreg_r31_old", rreg_db, 32'h0);
    begin_cycle();
    mid();
    check_value("rreg_r31", rreg_db, 32'hFFFFFFFF);
    check_value("fast_r31", fast_db, 32'hFFFFFFFF);

    // Write to r0 is ignored
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 0; data_writeReg = 32'hAAAA5555; ctrl_readRegA = 0;
    mid();
    check_value("r0_byp_fast", fast_da, 32'h0);
    begin_cycle();
    mid();
    check_value("r0_fast", fast_da, 32'h0);
    check_value("r0_small", small_da, 32'h0);

    // Bypass on r3
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 3; data_writeReg = 32'hCAFEF00D; ctrl_readRegA = 3;
    mid();
    check_value("byp_fast_r3", fast_da, 32'hCAFEF00D);
    check_value("byp_fast_r3_busy", 32'(fast_ba), 32'h0);
    check_value("nobyp_small_r3", small_da, 32'h0);
    begin_cycle();
    mid();
    check_value("late_small_r3", small_da, 32'hCAFEF00D);
    check_value("rreg_r3_old", rreg_da, 32'h0);
    begin_cycle();
    mid();
    check_value("rreg_r3", rreg_da, 32'hCAFEF00D);

    // Scoreboard on r9
    begin_cycle(); ctrl_setBusy = 1; ctrl_busyReg = 9; ctrl_readRegB = 9;
    mid();
    check_value("set_fast_same_cyc", 32'(fast_bb), 32'h0);
    begin_cycle();
    mid();
    check_value("busy_fast_r9", 32'(fast_bb), 32'h1);
    check_value("busy_small_r9", 32'(small_bb), 32'h1);
    check_value("busy_rreg_r9_lag", 32'(rreg_bb), 32'h0);
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 9; data_writeReg = 32'h42;
    mid();
    check_value("clr_byp_fast_busy", 32'(fast_bb), 32'h0);
    check_value("clr_byp_fast_data", fast_db, 32'h42);
    check_value("clr_small_busy_old", 32'(small_bb), 32'h1);
    check_value("clr_small_data_old", small_db, 32'h0);
    check_value("clr_rreg_busy", 32'(rreg_bb), 32'h1);
    begin_cycle();
    mid();
    check_value("clr_fast_busy", 32'(fast_bb), 32'h0);
    check_value("clr_small_busy", 32'(small_bb), 32'h0);
    check_value("clr_small_data", small_db, 32'h42);
    check_value("clr_rreg_busy_lag", 32'(rreg_bb), 32'h1);
    check_value("clr_rreg_data_lag", rreg_db, 32'h0);
    begin_cycle();
    mid();
    check_value("clr_rreg_busy_new", 32'(rreg_bb), 32'h0);
    check_value("clr_rreg_data_new", rreg_db, 32'h42);

    // setBusy and write to r9 together: set wins
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 9; data_writeReg = 32'h99;
    ctrl_setBusy = 1; ctrl_busyReg = 9;
    mid();
    check_value("both_byp_fast_busy", 32'(fast_bb), 32'h1);
    check_value("both_byp_fast_data", fast_db, 32'h99);
    check_value("both_small_busy_old", 32'(small_bb), 32'h0);
    check_value("both_small_data_old", small_db, 32'h42);
    begin_cycle();
    mid();
    check_value("both_fast_busy", 32'(fast_bb), 32'h1);
    check_value("both_small_busy", 32'(small_bb), 32'h1);
    check_value("both_small_data", small_db, 32'h99);
    check_value("both_rreg_busy_lag", 32'(rreg_bb), 32'h0);
    check_value("both_rreg_data_lag", rreg_db, 32'h42);

    // Registered read latency
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 4; data_writeReg = 32'h1; ctrl_readRegA = 4;
    mid();
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 6; data_writeReg = 32'h2;
    mid();
    begin_cycle();
    mid();
    check_value("lat_rreg_r4", rreg_da, 32'h1);
    begin_cycle(); ctrl_readRegA = 6;
    mid();
    check_value("lat_rreg_hold", rreg_da, 32'h1);
    check_value("lat_fast_r6", fast_da, 32'h2);
    begin_cycle();
    mid();
    check_value("lat_rreg_r6", rreg_da, 32'h2);

    // Depth: r20 unimplemented in the 16-register instance
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 20; data_writeReg = 32'h55;
    ctrl_setBusy = 1; ctrl_busyReg = 20; ctrl_readRegA = 20;
    mid();
    check_value("depth_small_r20_same", small_da, 32'h0);
    check_value("depth_small_r20_busy_same", 32'(small_ba), 32'h0);
    check_value("depth_fast_r20_byp", fast_da, 32'h55);
    check_value("depth_fast_r20_byp_busy", 32'(fast_ba), 32'h1);
    begin_cycle();
    mid();
    check_value("depth_small_r20", small_da, 32'h0);
    check_value("depth_small_r20_busy", 32'(small_ba), 32'h0);
    check_value("depth_fast_r20", fast_da, 32'h55);
    check_value("depth_fast_r20_busy", 32'(fast_ba), 32'h1);
    begin_cycle(); ctrl_writeEnable = 1; ctrl_writeReg = 15; data_writeReg = 32'h0F0F; ctrl_readRegA = 15;
    mid();
    begin_cycle();
    mid();
    check_value("depth_small_r15", small_da, 32'h0F0F);

    // setBusy on r0 is ignored
    begin_cycle(); ctrl_setBusy = 1; ctrl_busyReg = 0; ctrl_readRegA = 0;
    mid();
    begin_cycle();
    mid();
    check_value("r0_busy_fast", 32'(fast_ba), 32'h0);
    check_value("r0_busy_small", 32'(small_ba), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
